// File: rtl/chipset_pkg.sv
// Chipset-wide constants shared by the UART receive path and the CPU port decode.
// Pure definitions: no logic, no latency, no flow control.
package chipset_pkg;

    localparam int UART_FIFO_AW = 4;

    localparam int ST_AVAIL = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_OVF   = 5;

    localparam logic [3:0] UART_DATA_ADDR = 4'h8;

endpackage

// File: rtl/rx_fifo_ram.sv
// Byte storage for the UART receive FIFO: synchronous write, asynchronous read.
// Write lands on the clock edge; the read port follows raddr combinationally; no backpressure.
module rx_fifo_ram #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    // No reset on storage so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte strobe and the CPU data port; head byte is first-word-fall-through.
// Pushed byte visible one cycle after the strobe edge; when full, new bytes are dropped and overflow is latched.
module uart_rx_fifo
    import chipset_pkg::*;
#(
    parameter int AW = UART_FIFO_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        rd,
    input  logic        clr_ovf,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        full,
    output logic        overflow,
    output logic [AW:0] count,
    output logic [7:0]  status
);

    localparam int CW    = AW + 1;
    localparam int DEPTH = 2**AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rdy_q;
    logic          rd_q;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          pop_ok;
    logic [CW-1:0] count_nxt;
    logic [7:0]    ram_rdata;
    logic [3:0]    status_cnt;

    // Pop on the falling edge of rd so dout holds steady for the whole CPU read.
    assign push_req = rx_ready & ~rdy_q;
    assign pop_req  = rd_q & ~rd;
    assign pop_ok   = pop_req & ~empty;
    assign push_ok  = push_req & (~full | pop_ok);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rdy_q    <= 1'b0;
            rd_q     <= 1'b0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rdy_q <= rx_ready;
            rd_q  <= rd;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
            // A drop wins over a coincident clear so the lost byte is never hidden.
            if (push_req && full && !pop_req) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    rx_fifo_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign dout = empty ? 8'h00 : ram_rdata;

    // Status nibble saturates: a full 16-entry FIFO reads as F, not 0.
    always_comb begin
        status_cnt = 4'(count);
        if (32'(count) > 32'd15) begin
            status_cnt = 4'hF;
        end
        status           = 8'h00;
        status[ST_AVAIL] = ~empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = overflow;
        status[3:0]      = status_cnt;
    end

endmodule
